// File: rtl/ha_pkg.sv
// Shared types for the half-adder result path.
package ha_pkg;

  localparam int unsigned RES_W = 2;

  typedef struct packed {
    logic carry;
    logic sum;
  } ha_result_t;

endpackage

// File: rtl/ha_sync_fifo.sv
// Synchronous FIFO. Wrap-bit pointers give full/empty and occupancy.
// The head is shown combinationally and reads as zero while empty.
module ha_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO succeeds only when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/ha_result_packer.sv
// Packs LANES consecutive half-adder results into words, buffers them,
// flags illegal sum&carry results and counts words dropped on overflow.
module ha_result_packer
  import ha_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_sum,
  input  logic                     in_carry,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*LANES-1:0]       out_data,
  output logic [$clog2(DEPTH):0]   out_level,
  output logic                     err_illegal,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int unsigned WORD_W = LANES * RES_W;
  localparam int unsigned IDX_W  = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic [IDX_W-1:0]  lane_idx;
  logic [WORD_W-1:0] partial;
  logic [WORD_W-1:0] word_next;
  ha_result_t        cur;
  logic              accept;
  logic              complete;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop;

  assign cur      = '{carry: in_carry, sum: in_sum};
  assign accept   = in_valid & ~flush;
  assign complete = accept & (lane_idx == LAST_IDX);
  assign pop      = out_valid & out_ready;
  assign drop     = complete & fifo_full & ~pop;
  assign out_valid = ~fifo_empty;

  always_comb begin
    word_next = partial;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (IDX_W'(i) == lane_idx) word_next[i*RES_W +: RES_W] = cur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_idx    <= '0;
      partial     <= '0;
      err_illegal <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      if (flush) begin
        lane_idx <= '0;
        partial  <= '0;
      end else if (accept) begin
        if (complete) begin
          lane_idx <= '0;
          partial  <= '0;
        end else begin
          lane_idx <= lane_idx + 1'b1;
          partial  <= word_next;
        end
      end
      if (in_valid & in_sum & in_carry) err_illegal <= 1'b1;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  ha_sync_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (complete),
    .pop   (pop),
    .wdata (word_next),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (out_level)
  );

endmodule
